// File: rtl/vxv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vxv_pkg
//  Purpose  : Shared defaults, padding/chunk helpers and FSM encoding for VxV
//  Revision : 1.0 - initial release
// ============================================================================
package vxv_pkg;

  localparam int c_element_width = 32;
  localparam int c_no_of_units   = 8;
  localparam int c_num_eq        = 9;

  // An exact multiple still gets a full chunk of padding; that chunk is all zeros.
  function automatic int calc_additional(input int num_eq, input int units);
    return units - (num_eq % units);
  endfunction

  function automatic int calc_total(input int num_eq, input int units);
    return num_eq + calc_additional(num_eq, units);
  endfunction

  function automatic int calc_chunks(input int num_eq, input int units);
    return calc_total(num_eq, units) / units;
  endfunction

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/vxv_dot_engine_if.sv
`default_nettype none
// ============================================================================
//  Module   : vxv_dot_engine_if
//  Purpose  : Start/operand/result bundle between VxV memory and dot engine
//  Revision : 1.0 - initial release
// ============================================================================
interface vxv_dot_engine_if
  import vxv_pkg::*;
#(
  parameter int ELEMENT_WIDTH = c_element_width,
  parameter int NO_OF_UNITS   = c_no_of_units,
  parameter int NUM_EQ        = c_num_eq
);
  localparam int c_total = calc_total(NUM_EQ, NO_OF_UNITS);

  logic                             start;
  logic [ELEMENT_WIDTH*c_total-1:0] vec_a;
  logic [ELEMENT_WIDTH*c_total-1:0] vec_b;
  logic                             busy;
  logic                             done;
  logic [ELEMENT_WIDTH-1:0]         result;

  modport master (
    output start, vec_a, vec_b,
    input  busy, done, result
  );

  modport slave (
    input  start, vec_a, vec_b,
    output busy, done, result
  );

endinterface
`default_nettype wire

// File: rtl/vxv_chunk_mac.sv
`default_nettype none
// ============================================================================
//  Module   : vxv_chunk_mac
//  Purpose  : Combinational wrapped multiply-add over one chunk of slots
//  Revision : 1.0 - initial release
// ============================================================================
module vxv_chunk_mac
  import vxv_pkg::*;
#(
  parameter int ELEMENT_WIDTH = c_element_width,
  parameter int NO_OF_UNITS   = c_no_of_units
) (
  input  wire logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] a_chunk,
  input  wire logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] b_chunk,
  output logic      [ELEMENT_WIDTH-1:0]             sum
);

  logic [ELEMENT_WIDTH-1:0] w_prod [NO_OF_UNITS];

  // Low ELEMENT_WIDTH bits of a signed product equal those of the unsigned one.
  for (genvar i = 0; i < NO_OF_UNITS; i++) begin : g_mul
    assign w_prod[i] = a_chunk[i*ELEMENT_WIDTH +: ELEMENT_WIDTH]
                     * b_chunk[i*ELEMENT_WIDTH +: ELEMENT_WIDTH];
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < NO_OF_UNITS; i++) begin
      sum = sum + w_prod[i];
    end
  end

endmodule
`default_nettype wire

// File: rtl/vxv_dot_engine.sv
`default_nettype none
// ============================================================================
//  Module   : vxv_dot_engine
//  Purpose  : Signed chunked dot product of two zero-padded VxV vectors
//  Revision : 1.0 - initial release
// ============================================================================
module vxv_dot_engine
  import vxv_pkg::*;
#(
  parameter int ELEMENT_WIDTH = c_element_width,
  parameter int NO_OF_UNITS   = c_no_of_units,
  parameter int NUM_EQ        = c_num_eq
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  vxv_dot_engine_if.slave   bus
);

  localparam int c_total   = calc_total(NUM_EQ, NO_OF_UNITS);
  localparam int c_chunks  = calc_chunks(NUM_EQ, NO_OF_UNITS);
  localparam int c_chunk_w = ELEMENT_WIDTH * NO_OF_UNITS;
  localparam int c_cnt_w   = (c_chunks > 1) ? $clog2(c_chunks) : 1;
  localparam logic [c_cnt_w-1:0] c_last_chunk = c_cnt_w'(c_chunks - 1);

  state_t                           r_state;
  logic [c_cnt_w-1:0]               r_chunk;
  logic [ELEMENT_WIDTH*c_total-1:0] r_vec_a;
  logic [ELEMENT_WIDTH*c_total-1:0] r_vec_b;
  logic [ELEMENT_WIDTH-1:0]         r_acc;
  logic [ELEMENT_WIDTH-1:0]         r_result;
  logic                             r_busy;
  logic                             r_done;

  logic [c_chunk_w-1:0]             w_a_chunk;
  logic [c_chunk_w-1:0]             w_b_chunk;
  logic [ELEMENT_WIDTH-1:0]         w_chunk_sum;

  // Constant-slice mux keeps the chunk select free of variable part-selects.
  always_comb begin
    w_a_chunk = '0;
    w_b_chunk = '0;
    for (int c = 0; c < c_chunks; c++) begin
      if (r_chunk == c_cnt_w'(c)) begin
        w_a_chunk = r_vec_a[c*c_chunk_w +: c_chunk_w];
        w_b_chunk = r_vec_b[c*c_chunk_w +: c_chunk_w];
      end
    end
  end

  vxv_chunk_mac #(
    .ELEMENT_WIDTH (ELEMENT_WIDTH),
    .NO_OF_UNITS   (NO_OF_UNITS)
  ) u_chunk_mac (
    .a_chunk (w_a_chunk),
    .b_chunk (w_b_chunk),
    .sum     (w_chunk_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_chunk  <= '0;
      r_vec_a  <= '0;
      r_vec_b  <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_vec_a <= bus.vec_a;
            r_vec_b <= bus.vec_b;
            r_chunk <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (r_chunk == c_last_chunk) begin
            r_result <= r_acc + w_chunk_sum;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= ST_IDLE;
          end else begin
            r_acc   <= r_acc + w_chunk_sum;
            r_chunk <= r_chunk + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;

endmodule
`default_nettype wire
